hazard_tag_pipe: RTL and testbench

Back-end producer of the hazard/forwarding tags in the 5-stage RV32 pipeline. It carries per-instruction register tags (rs1, rs2, rd, regwrite, memread) from decode through the ID/EX, EX/MEM and MEM/WB stages. It drives the rs/rd/regwrite/memread values that the forwarding and hazard-detection logic consume. It applies that logic's bubble request (ctrlf), branch flushes and data-memory freezes, and counts stall and flush cycles.

---
 rtl/hazard_tag_pipe_pkg.sv | 18 +
 rtl/hazard_tag_pipe_stage.sv | 22 ++
 rtl/hazard_tag_pipe.sv | 111 +++++++++++
 tb/tb_hazard_tag_pipe.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_tag_pipe_pkg.sv
// Shared types for the hazard/forwarding tag pipeline.
// A tag is the per-instruction register info that the hazard unit tracks.
package hazard_tag_pipe_pkg;

    localparam int REG_AW = 5;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } tag_t;

    localparam tag_t TAG_BUBBLE = '0;

endpackage

// File: rtl/hazard_tag_pipe_stage.sv
// One pipeline register holding a tag_t.
// Hold wins over bubble, and bubble wins over load.
module hazard_tag_stage
    import hazard_tag_pipe_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic hold,
    input  logic bubble,
    input  tag_t d,
    output tag_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= TAG_BUBBLE;
        end else if (!hold) begin
            q <= bubble ? TAG_BUBBLE : d;
        end
    end

endmodule

// File: rtl/hazard_tag_pipe.sv
// ID/EX, EX/MEM and MEM/WB tag registers feeding forwarding and hazard detection,
// with freeze/flush/bubble priority and saturating stall and flush counters.
module hazard_tag_pipe
    import hazard_tag_pipe_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              ctrlf,
    input  logic              ex_flush,
    input  logic              dmem_stall,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_memread,
    output logic [REG_AW-1:0] mem_rd,
    output logic              mem_regwrite,
    output logic [REG_AW-1:0] wb_rd,
    output logic              wb_regwrite,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    tag_t id_tag;
    tag_t idex_q;
    tag_t exmem_q;
    tag_t memwb_q;
    logic idex_bubble;
    logic stall_inc;
    logic flush_inc;
    logic unused_fields;

    // Write enables are sanitised on entry so x0 writes are never advertised downstream.
    always_comb begin
        id_tag          = TAG_BUBBLE;
        id_tag.valid    = id_valid;
        id_tag.rs1      = id_rs1;
        id_tag.rs2      = id_rs2;
        id_tag.rd       = id_rd;
        id_tag.regwrite = id_regwrite & id_valid & (id_rd != '0);
        id_tag.memread  = id_memread & id_valid;
    end

    assign idex_bubble = ex_flush | ctrlf | ~id_valid;
    assign stall_inc   = dmem_stall | (ctrlf & ~ex_flush);
    assign flush_inc   = ex_flush & ~dmem_stall;

    hazard_tag_stage u_idex (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (dmem_stall),
        .bubble (idex_bubble),
        .d      (id_tag),
        .q      (idex_q)
    );

    hazard_tag_stage u_exmem (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (dmem_stall),
        .bubble (1'b0),
        .d      (idex_q),
        .q      (exmem_q)
    );

    hazard_tag_stage u_memwb (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (dmem_stall),
        .bubble (1'b0),
        .d      (exmem_q),
        .q      (memwb_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_inc && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign ex_rs1       = idex_q.rs1;
    assign ex_rs2       = idex_q.rs2;
    assign ex_rd        = idex_q.rd;
    assign ex_memread   = idex_q.memread;
    assign mem_rd       = exmem_q.rd;
    assign mem_regwrite = exmem_q.regwrite;
    assign wb_rd        = memwb_q.rd;
    assign wb_regwrite  = memwb_q.regwrite;

    // Later stages carry the full tag for uniformity; these fields have no consumer here.
    assign unused_fields = ^{idex_q.valid, idex_q.regwrite,
                             exmem_q.valid, exmem_q.rs1, exmem_q.rs2, exmem_q.memread,
                             memwb_q.valid, memwb_q.rs1, memwb_q.rs2, memwb_q.memread};

endmodule

// File: tb/tb_hazard_tag_pipe.sv
// Self-checking bench for hazard_tag_pipe: directed scenarios plus random traffic
// compared against a shift-list model of the pipeline's tags and counters.
module tb_hazard_tag_pipe;

    localparam int AW   = 5;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          id_valid = 1'b0;
    logic [AW-1:0] id_rs1 = '0;
    logic [AW-1:0] id_rs2 = '0;
    logic [AW-1:0] id_rd = '0;
    logic          id_regwrite = 1'b0;
    logic          id_memread = 1'b0;
    logic          ctrlf = 1'b0;
    logic          ex_flush = 1'b0;
    logic          dmem_stall = 1'b0;
    logic [AW-1:0] ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic          ex_memread, mem_regwrite, wb_regwrite;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [35:0]   obs;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          v;
        bit [AW-1:0] rs1;
        bit [AW-1:0] rs2;
        bit [AW-1:0] rd;
        bit          rw;
        bit          mr;
    } mtag_t;

    mtag_t pipe[3];
    int    m_stall;
    int    m_flush;

    always #5 clk = ~clk;

    hazard_tag_pipe #(.REG_AW(AW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_regwrite  (id_regwrite),
        .id_memread   (id_memread),
        .ctrlf        (ctrlf),
        .ex_flush     (ex_flush),
        .dmem_stall   (dmem_stall),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_rd        (ex_rd),
        .ex_memread   (ex_memread),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    assign obs = {ex_rs1, ex_rs2, ex_rd, ex_memread, mem_rd, mem_regwrite,
                  wb_rd, wb_regwrite, stall_cnt, flush_cnt};

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
        m_stall = 0;
        m_flush = 0;
    endfunction

    // Model: the pipe is a 3-entry list that shifts by one on any non-frozen edge.
    function automatic void model_step();
        mtag_t nt;
        nt = '{default: 0};
        if (dmem_stall) begin
            m_stall = (m_stall == CMAX) ? CMAX : m_stall + 1;
        end else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (ex_flush) begin
                m_flush = (m_flush == CMAX) ? CMAX : m_flush + 1;
            end else if (ctrlf) begin
                m_stall = (m_stall == CMAX) ? CMAX : m_stall + 1;
            end else if (id_valid) begin
                nt = '{1, id_rs1, id_rs2, id_rd, id_regwrite && (id_rd != 0), id_memread};
            end
            pipe[0] = nt;
        end
    endfunction

    function automatic logic [35:0] expected();
        return {pipe[0].rs1, pipe[0].rs2, pipe[0].rd, pipe[0].mr,
                pipe[1].rd, pipe[1].rw, pipe[2].rd, pipe[2].rw,
                CW'(m_stall), CW'(m_flush)};
    endfunction

    task automatic cycle(input bit v, input bit [AW-1:0] a, input bit [AW-1:0] b,
                         input bit [AW-1:0] d, input bit rw, input bit mr,
                         input bit ct, input bit fl, input bit ds);
        id_valid = v; id_rs1 = a; id_rs2 = b; id_rd = d;
        id_regwrite = rw; id_memread = mr;
        ctrlf = ct; ex_flush = fl; dmem_stall = ds;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        id_valid = 0; ctrlf = 0; ex_flush = 0; dmem_stall = 0;
        rst_n = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_reset();
        id_valid = 1; id_rs1 = 5'd11; id_rs2 = 5'd12; id_rd = 5'd13;
        id_regwrite = 1; id_memread = 1;
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== 36'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs obs=%h expected=0", obs);
        end
        rst_n = 1;
        cycle(1, 1, 2, 5, 1, 0, 0, 0, 0);
        checks++;
        if (ex_rd !== 5'd5) begin
            failures++;
            $display("[TB] FAIL latency_ex ex_rd=%0d expected=5", ex_rd);
        end
        idle();
        checks++;
        if (mem_rd !== 5'd5 || mem_regwrite !== 1'b1) begin
            failures++;
            $display("[TB] FAIL latency_mem mem_rd=%0d mem_regwrite=%b expected=5/1", mem_rd, mem_regwrite);
        end
        idle();
        checks++;
        if (wb_rd !== 5'd5 || wb_regwrite !== 1'b1) begin
            failures++;
            $display("[TB] FAIL latency_wb wb_rd=%0d wb_regwrite=%b expected=5/1", wb_rd, wb_regwrite);
        end
    endtask

    task automatic test_x0_filter();
        do_reset();
        cycle(1, 3, 4, 0, 1, 0, 0, 0, 0);
        idle();
        checks++;
        if (mem_regwrite !== 1'b0) begin
            failures++;
            $display("[TB] FAIL x0_mem mem_regwrite=%b expected=0", mem_regwrite);
        end
        idle();
        checks++;
        if (wb_regwrite !== 1'b0) begin
            failures++;
            $display("[TB] FAIL x0_wb wb_regwrite=%b expected=0", wb_regwrite);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        cycle(1, 1, 2, 7, 1, 1, 0, 0, 0);
        checks++;
        if (ex_memread !== 1'b1 || ex_rd !== 5'd7) begin
            failures++;
            $display("[TB] FAIL load_in_ex ex_memread=%b ex_rd=%0d expected=1/7", ex_memread, ex_rd);
        end
        cycle(1, 7, 0, 8, 1, 0, 1, 0, 0);
        checks++;
        if (ex_memread !== 1'b0 || ex_rd !== 5'd0 || mem_rd !== 5'd7 || stall_cnt !== 4'd1) begin
            failures++;
            $display("[TB] FAIL load_use ex_memread=%b ex_rd=%0d mem_rd=%0d stall_cnt=%0d expected=0/0/7/1",
                     ex_memread, ex_rd, mem_rd, stall_cnt);
        end
    endtask

    task automatic test_freeze();
        logic [27:0] snap;
        do_reset();
        cycle(1, 0, 0, 6, 1, 0, 0, 0, 0);
        cycle(1, 0, 0, 4, 1, 0, 0, 0, 0);
        cycle(1, 0, 0, 3, 1, 0, 0, 0, 0);
        snap = obs[35:8];
        for (int i = 0; i < 4; i++) begin
            cycle(1, 7, 7, 7, 1, 1, i[0], 0, 1);
            checks++;
            if (obs[35:8] !== snap) begin
                failures++;
                $display("[TB] FAIL freeze_hold cycle=%0d obs=%h expected=%h", i, obs[35:8], snap);
            end
        end
        checks++;
        if (stall_cnt !== 4'd4 || ex_rd !== 5'd3 || mem_rd !== 5'd4 || wb_rd !== 5'd6) begin
            failures++;
            $display("[TB] FAIL freeze_state stall_cnt=%0d rds=%0d/%0d/%0d expected=4 3/4/6",
                     stall_cnt, ex_rd, mem_rd, wb_rd);
        end
        cycle(1, 0, 0, 8, 1, 0, 0, 0, 0);
        checks++;
        if (ex_rd !== 5'd8 || mem_rd !== 5'd3 || wb_rd !== 5'd4) begin
            failures++;
            $display("[TB] FAIL freeze_release rds=%0d/%0d/%0d expected=8/3/4", ex_rd, mem_rd, wb_rd);
        end
    endtask

    task automatic test_flush_vs_bubble();
        do_reset();
        cycle(1, 1, 1, 9, 1, 0, 0, 0, 0);
        cycle(1, 9, 2, 10, 1, 1, 1, 1, 0);
        checks++;
        if (mem_rd !== 5'd9 || ex_rd !== 5'd0 || ex_memread !== 1'b0 ||
            flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
            failures++;
            $display("[TB] FAIL flush_vs_bubble mem_rd=%0d ex_rd=%0d ex_memread=%b flush=%0d stall=%0d expected=9/0/0/1/0",
                     mem_rd, ex_rd, ex_memread, flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 8) != 0, AW'($urandom), AW'($urandom), AW'($urandom % 8),
                  $urandom % 2, $urandom % 2, ($urandom % 5) == 0,
                  ($urandom % 7) == 0, ($urandom % 6) == 0);
            checks++;
            if (obs !== expected()) begin
                failures++;
                $display("[TB] FAIL random cycle=%0d obs=%h expected=%h", i, obs, expected());
            end
        end
    endtask

    task automatic test_saturation_async_reset();
        do_reset();
        for (int i = 0; i < 20; i++) cycle(1, 2, 3, 4, 1, 0, 1, 0, 0);
        checks++;
        if (stall_cnt !== 4'd15 || flush_cnt !== 4'd0) begin
            failures++;
            $display("[TB] FAIL saturation stall_cnt=%0d flush_cnt=%0d expected=15/0", stall_cnt, flush_cnt);
        end
        @(negedge clk);
        rst_n = 0;
        #1;
        checks++;
        if (obs !== 36'd0) begin
            failures++;
            $display("[TB] FAIL async_reset obs=%h expected=0", obs);
        end
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
        cycle(1, 1, 2, 5, 1, 0, 0, 0, 0);
        checks++;
        if (ex_rd !== 5'd5 || obs !== expected()) begin
            failures++;
            $display("[TB] FAIL post_reset_load ex_rd=%0d obs=%h expected=%h", ex_rd, obs, expected());
        end
    endtask

    initial begin
        test_reset();
        test_x0_filter();
        test_load_use();
        test_freeze();
        test_flush_vs_bubble();
        test_random();
        test_saturation_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] timeout");
    end

endmodule
